// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared definitions for the Common Data Bus arbiter.
//   - default sizing for the FU count, tag width and result width
//   - ZERO_REG: tag value meaning "no producer"; never broadcast
//   - cdb_packet_t: one broadcast as seen by map table, RS and ROB
package cdb_arbiter_pkg;

    localparam int CDB_NUM_FU = 5;
    localparam int CDB_TAG_W  = 5;
    localparam int CDB_XLEN   = 32;

    localparam logic [CDB_TAG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_select.sv
// cdb_arbiter_rr_priority_select
//   Combinational round-robin select: picks the first set request at or
//   after ptr, wrapping modulo N.
//   Ports:
//     req        in   N       request vector
//     ptr        in   IDX_W   highest-priority index this cycle (< N)
//     grant      out  N       one-hot grant, zero when no request
//     any        out  1       at least one request present
//     grant_idx  out  IDX_W   index of the granted request
module cdb_arbiter_rr_priority_select #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Doubling the vector lets a plain right shift act as a rotate,
        // so bit 0 of rot is the request at ptr.
        rot = N'({req, req} >> ptr);
        any = |req;

        // Scan downwards so the lowest set bit is the one left in offset.
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDX_W'(i);
            end
        end

        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        grant_idx = sum[IDX_W-1:0];

        grant = '0;
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the single Common Data Bus between NUM_FU completion requesters.
//   Round-robin, one winner per cycle; the winner's tag/value appear on the
//   registered bus the following cycle for exactly one cycle.
//   Ports:
//     clock         in   1              system clock
//     reset         in   1              synchronous, active-high
//     squash        in   1              flush: no grant this cycle, bus idle next
//     fu_valid      in   NUM_FU         FU i has a completed result pending
//     fu_tag        in   NUM_FU*TAG_W   destination tag per FU
//     fu_value      in   NUM_FU*XLEN    result value per FU
//     fu_ack        out  NUM_FU         one-hot grant, FU retires request
//     cdb_valid     out  1              broadcast valid (registered)
//     cdb_tag       out  TAG_W          broadcast tag, 0 when idle
//     cdb_value     out  XLEN           broadcast value, 0 when idle
//     err_zero_tag  out  1              sticky: a valid request used tag 0
//     bcast_cnt     out  32             broadcasts since reset, wraps
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int XLEN   = CDB_XLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_ack,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic                    err_zero_tag,
    output logic [31:0]             bcast_cnt
);

    localparam int IDX_W = $clog2(NUM_FU);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic [NUM_FU-1:0] zero_tag;
    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] grant;
    logic              any;
    logic [TAG_W-1:0]  win_tag;
    logic [XLEN-1:0]   win_value;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            zero_tag[i] = (fu_tag[i*TAG_W +: TAG_W] == TAG_W'(ZERO_REG));
        end
    end

    // Reset and squash suppress every grant; a zero-tag request is never
    // eligible, so it can only raise the error flag.
    assign elig = fu_valid & ~zero_tag & {NUM_FU{~(squash | reset)}};

    cdb_arbiter_rr_priority_select #(
        .N     (NUM_FU),
        .IDX_W (IDX_W)
    ) u_select (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any       (any),
        .grant_idx (win_idx)
    );

    assign fu_ack = grant;

    always_comb begin
        win_tag   = '0;
        win_value = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                win_tag   = fu_tag[i*TAG_W +: TAG_W];
                win_value = fu_value[i*XLEN +: XLEN];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(NUM_FU - 1)) ? '0 : win_idx + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
            rr_ptr       <= '0;
            err_zero_tag <= 1'b0;
            bcast_cnt    <= '0;
        end else begin
            if (any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= win_tag;
                cdb_value <= win_value;
                rr_ptr    <= ptr_next;
                bcast_cnt <= bcast_cnt + 32'd1;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_value <= '0;
            end
            if (|(fu_valid & zero_tag)) begin
                err_zero_tag <= 1'b1;
            end
        end
    end

endmodule
